// File: rtl/det2_share_arbiter.sv
// Round-robin arbiter sharing one 2x2 determinant unit between two requesters.
// Optional watchdog in WAIT is compiled in with `define DET2_ARB_TIMEOUT_EN.
module det2_share_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] opnd0,
    input  logic [31:0] opnd1,
    output logic [1:0]  ack,
    output logic [15:0] result,
    output logic        err,
    output logic        busy,
    output logic        u_start,
    output logic [7:0]  u_a,
    output logic [7:0]  u_b,
    output logic [7:0]  u_c,
    output logic [7:0]  u_d,
    input  logic [15:0] u_result,
    input  logic        u_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_r;
    state_t next_s;
    logic   g_r;
    logic   lp_r;
    logic   grant_s;
    logic   timeout_s;

    // Round-robin pick: a lone requester wins, on contention the one not served last.
    always_comb begin
        grant_s = 1'b0;
        if (req == 2'b10) begin
            grant_s = 1'b1;
        end else if (req == 2'b11) begin
            grant_s = ~lp_r;
        end else begin
            grant_s = 1'b0;
        end
    end

`ifdef DET2_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] wait_cnt_r;

    // Watchdog counter: cleared while issuing, counts every WAIT cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (state_r == ISSUE) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign timeout_s = (state_r == WAIT) && (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic; u_done only matters while in WAIT.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    next_s = ISSUE;
                end else begin
                    next_s = IDLE;
                end
            end
            ISSUE: next_s = WAIT;
            WAIT: begin
                if (u_done || timeout_s) begin
                    next_s = RESP;
                end else begin
                    next_s = WAIT;
                end
            end
            RESP:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State, grant bookkeeping and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            g_r     <= 1'b0;
            lp_r    <= 1'b1;
            ack     <= 2'b00;
            result  <= 16'h0000;
            err     <= 1'b0;
            busy    <= 1'b0;
            u_start <= 1'b0;
            u_a     <= 8'h00;
            u_b     <= 8'h00;
            u_c     <= 8'h00;
            u_d     <= 8'h00;
        end else begin
            state_r <= next_s;
            u_start <= (state_r == IDLE) && (next_s == ISSUE);
            busy    <= (next_s != IDLE);
            ack     <= 2'b00;
            err     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (next_s == ISSUE) begin
                        g_r <= grant_s;
                        {u_a, u_b, u_c, u_d} <= grant_s ? opnd1 : opnd0;
                    end
                end
                WAIT: begin
                    // A real completion takes priority over a same-cycle watchdog expiry.
                    if (u_done) begin
                        result <= u_result;
                        ack    <= g_r ? 2'b10 : 2'b01;
                    end else if (timeout_s) begin
                        result <= 16'h0000;
                        err    <= 1'b1;
                        ack    <= g_r ? 2'b10 : 2'b01;
                    end
                end
                RESP: lp_r <= g_r;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_det2_share_arbiter.sv
// Directed self-checking bench for det2_share_arbiter; the bench plays the shared unit.
module tb_det2_share_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] opnd0;
    logic [31:0] opnd1;
    logic [1:0]  ack;
    logic [15:0] result;
    logic        err;
    logic        busy;
    logic        u_start;
    logic [7:0]  u_a, u_b, u_c, u_d;
    logic [15:0] u_result;
    logic        u_done;

    int checks = 0;
    int errors = 0;

    det2_share_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .req(req), .opnd0(opnd0), .opnd1(opnd1),
        .ack(ack), .result(result), .err(err), .busy(busy), .u_start(u_start),
        .u_a(u_a), .u_b(u_b), .u_c(u_c), .u_d(u_d),
        .u_result(u_result), .u_done(u_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = 2'b00;
        u_done   = 1'b0;
        u_result = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Starts in an IDLE cycle with req driven; ends in the RESP cycle.
    task automatic run_job(input string tag, input logic [1:0] exp_ack,
                           input logic [31:0] exp_ops, input logic [15:0] res, input int lat);
        tick();
        check({tag, "_start"}, {31'd0, u_start}, 32'd1);
        check({tag, "_ops"}, {u_a, u_b, u_c, u_d}, exp_ops);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < lat; i++) begin
            tick();
            check({tag, "_wait"}, {29'd0, ack, u_start}, 32'd0);
        end
        u_done   = 1'b1;
        u_result = res;
        tick();
        u_done = 1'b0;
        check({tag, "_ack"}, {30'd0, ack}, {30'd0, exp_ack});
        check({tag, "_result"}, {16'd0, result}, {16'd0, res});
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; opnd0 = 32'h0; opnd1 = 32'h0;
        u_done = 1'b0; u_result = 16'h0;

        // Reset state
        do_reset();
        check("rst_ack", {30'd0, ack}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_flags", {29'd0, err, busy, u_start}, 32'd0);
        check("rst_ops", {u_a, u_b, u_c, u_d}, 32'd0);

        // Single job: 3*4 - 2*1 = 10, unit latency 5
        opnd0 = 32'h03020104;
        req   = 2'b01;
        run_job("single", 2'b01, 32'h03020104, 16'd10, 5);
        req = 2'b00;
        tick();
        check("single_idle_busy", {31'd0, busy}, 32'd0);
        check("single_idle_ack", {30'd0, ack}, 32'd0);

        // Contention from reset: 0, then 1, then 0
        do_reset();
        opnd0 = 32'h03020104;
        opnd1 = 32'h00050200;
        req   = 2'b11;
        run_job("cont0", 2'b01, 32'h03020104, 16'd10, 3);
        tick();
        run_job("cont1", 2'b10, 32'h00050200, 16'hFFF6, 2);
        tick();
        run_job("cont2", 2'b01, 32'h03020104, 16'd10, 2);
        req = 2'b00;
        tick();

        // Back-to-back: requester 1 keeps req high through IDLE
        do_reset();
        opnd1 = 32'h00050200;
        req   = 2'b10;
        run_job("b2b0", 2'b10, 32'h00050200, 16'hFFF6, 2);
        opnd1 = 32'h05000005;
        tick();
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        run_job("b2b1", 2'b10, 32'h05000005, 16'd25, 2);
        req = 2'b00;
        tick();

        // Spurious u_done in IDLE and in ISSUE
        do_reset();
        u_done = 1'b1;
        tick();
        u_done = 1'b0;
        check("spur_idle", {29'd0, ack, busy}, 32'd0);
        opnd0 = 32'h01020304;
        req   = 2'b01;
        tick();
        check("spur_issue_start", {31'd0, u_start}, 32'd1);
        u_done   = 1'b1;
        u_result = 16'h1234;
        tick();
        u_done = 1'b0;
        check("spur_wait1", {29'd0, ack, busy}, 32'd1);
        tick();
        tick();
        check("spur_wait3", {29'd0, ack, busy}, 32'd1);
        u_done   = 1'b1;
        u_result = 16'hFFFE;
        tick();
        u_done = 1'b0;
        check("spur_ack", {30'd0, ack}, 32'd1);
        check("spur_result", {16'd0, result}, 32'h0000FFFE);
        req = 2'b00;
        tick();

        // Reset during WAIT drops the job; requester 0 wins afterwards
        do_reset();
        opnd0 = 32'h0A0B0C0D;
        opnd1 = 32'h01010101;
        req   = 2'b10;
        tick();
        tick();
        tick();
        check("rw_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_ack", {30'd0, ack}, 32'd0);
        check("rw_flags", {29'd0, err, busy, u_start}, 32'd0);
        check("rw_ops", {u_a, u_b, u_c, u_d}, 32'd0);
        req = 2'b11;
        tick();
        check("rw_regrant", {u_a, u_b, u_c, u_d}, 32'h0A0B0C0D);
        req = 2'b00;

        // Watchdog: u_done never arrives
        do_reset();
        opnd0 = 32'h02020202;
        req   = 2'b01;
        tick();
`ifdef DET2_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) tick();
        check("to_pre_ack", {30'd0, ack}, 32'd0);
        tick();
        check("to_ack", {30'd0, ack}, 32'd1);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_result", {16'd0, result}, 32'd0);
        req = 2'b00;
        tick();
        check("to_err_clear", {30'd0, err, busy}, 32'd0);
`else
        for (int i = 0; i < 20; i++) tick();
        check("nowd_busy", {31'd0, busy}, 32'd1);
        check("nowd_ack", {29'd0, ack, err}, 32'd0);
        req = 2'b00;
`endif
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/det2_share_arbiter.md
# det2_share_arbiter

Round-robin arbiter that shares one 2x2 determinant unit between two requesters, typically two 3x3 determinant engines or a 3x3 engine and a host port. It takes a four-byte operand set from the granted requester and sequences the shared unit through a start/done handshake. It returns the 16-bit result with a one-cycle acknowledge. Only one computation is in flight at a time.

## Interface
- `TIMEOUT_CYCLES`, default 64: watchdog limit in WAIT; used only when the watchdog is compiled in.
- `clock` input 1: single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `req` input 2: request per requester; bit i belongs to requester i.
- `opnd0` input 32: requester 0 operands, {a,b,c,d} = [31:24],[23:16],[15:8],[7:0]. The unit computes a*d - b*c.
- `opnd1` input 32: requester 1 operands, same packing.
- `ack` output 2: one-cycle pulse to the served requester.
- `result` output 16: result for the acked requester; valid only while `ack` != 0.
- `err` output 1: timeout flag, qualified by `ack`; constant 0 when the watchdog is compiled out.
- `busy` output 1: high in every state except IDLE.
- `u_start` output 1: one-cycle start pulse to the shared unit.
- `u_a`, `u_b`, `u_c`, `u_d` output 8 each: latched operands to the shared unit.
- `u_result` input 16: shared unit result.
- `u_done` input 1: shared unit completion pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, on any `req` bit high:
  - Grant one requester and latch its 32-bit operand word into `u_a`..`u_d`.
  - Record grant index `g`.
  - Go to ISSUE.
- ISSUE: `u_start`=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On `u_done`=1, capture `u_result` into the result register and go to RESP.
  - `u_done` is sampled only in WAIT. Any `u_done` seen in IDLE, ISSUE or RESP is ignored.
- RESP:
  - `ack[g]`=1 and `result` = captured value.
  - Update last-grant pointer `lp` to `g`, then go to IDLE.
- Round robin:
  - If only one `req` bit is high, that requester wins.
  - If both are high, the requester != `lp` wins.
  - `lp` resets to 1, so requester 0 wins the first contested grant.
- Requester rules:
  - Hold `req` and operands stable until `ack`.
  - Drop `req` in the cycle after `ack`. A `req` still high in that IDLE cycle is treated as a new request.
  - Deasserting `req` before `ack` does not cancel the in-flight job; the job completes and `ack` still pulses.
- Operands are latched at grant, so requester operand changes after the grant have no effect.
- `result` is passed through unmodified (two's complement as produced by the unit). The arbiter does no arithmetic.
- Reset values: `ack`=0, `result`=0, `err`=0, `busy`=0, `u_start`=0, `u_a`..`u_d`=0, state IDLE, `lp`=1.
- Reset mid-operation: any state returns to IDLE next cycle and the in-flight job is dropped with no `ack`. The shared unit shares the same `reset`.

## Timing
- `req` high in IDLE cycle T:
  - Cycle T+1: ISSUE, `u_start`=1, `u_a`..`u_d` valid.
  - Cycles T+2 onward: WAIT.
- `u_done` in WAIT cycle D:
  - Cycle D+1: RESP, with `ack` and `result` valid.
  - Cycle D+2: IDLE, where a new request may be sampled.
- Arbiter overhead is 3 cycles beyond the unit latency (grant, issue, response).
- Back-to-back minimum spacing is one IDLE cycle between jobs.
- `busy` goes high at T+1 and low at D+2.
- `u_done` in the same cycle `u_start` is asserted (ISSUE) is ignored. The unit must pulse `u_done` no earlier than T+2.

## Configuration
- Macro `DET2_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `u_done`, the FSM goes to RESP with `err`=1 and `result`=16'h0000, and `ack` pulses normally.
  - `err` clears after RESP.
- Undefined: no counter; WAIT holds indefinitely until `u_done`; `err` is tied to 0.

## Test plan
- Single job: requester 0 operands {3,2,1,4}, unit returns 16'd10 after 5 cycles → `u_start` at T+1, `ack`=2'b01, `result`=10 at D+1, `busy` low at D+2.
- Contention: both `req` high from reset; results 10 and 16'hFFF6 (-10) → requester 0 is served first, then requester 1, then requester 0 again; each sees only its own `ack`.
- Back-to-back: requester 1 re-requests the cycle after IDLE with operands {5,0,0,5} → second `u_start` exactly 2 cycles after the first `ack`, `result`=25.
- Spurious `u_done` in IDLE and in the ISSUE cycle → no state change, no `ack`; the job still waits for a WAIT-state `u_done`.
- `reset` asserted during WAIT → next cycle IDLE, all outputs 0, no `ack`; a new request after reset is granted to requester 0.
- With `DET2_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `u_done` never arrives → `ack` pulses with `err`=1 and `result`=0 after 8 WAIT cycles; without the macro, `busy` stays high.
